// File: rtl/ldpc_col_update_if.sv
// Handshake and data bundle between the LDPC column stage and its neighbours.
// master drives channel LLRs, check messages and i_ready; slave is the column stage.
interface ldpc_col_update_if #(
  parameter int W = 16
);
  logic signed [W-1:0] i_llr;
  logic                i_llr_val;
  logic signed [W-1:0] i_msg;
  logic                i_msg_val;
  logic signed [W-1:0] o_msg;
  logic                o_msg_val;
  logic                i_ready;
  logic                o_hard;
  logic                o_hard_val;
  logic                o_busy;

  modport master (
    output i_llr, i_llr_val, i_msg, i_msg_val, i_ready,
    input  o_msg, o_msg_val, o_hard, o_hard_val, o_busy
  );

  modport slave (
    input  i_llr, i_llr_val, i_msg, i_msg_val, i_ready,
    output o_msg, o_msg_val, o_hard, o_hard_val, o_busy
  );
endinterface

// File: rtl/ldpc_col_update.sv
// Min-sum LDPC variable-node stage: LLR + DEG check messages -> hard decision and DEG extrinsics.
// Optional LDPC_COL_SAT_EN: extrinsics clamp symmetrically to +/-(2^(W-1)-1) instead of wrapping.
module ldpc_col_update #(
  parameter int W    = 16,
  parameter int DEG  = 3,
  parameter int ACCW = 20
) (
  input  logic               clk,
  input  logic               xrst,
  ldpc_col_update_if.slave   bus
);
  localparam int CW = (DEG > 1) ? $clog2(DEG) : 1;

  typedef enum logic [1:0] {IDLE, ACC, OUT} state_t;

  state_t              state_q, state_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic signed [ACCW-1:0] acc_q, acc_d;
  logic signed [W-1:0] buf_q [DEG];
  logic signed [W-1:0] buf_d [DEG];
  logic                hard_q, hard_d;
  logic                hard_val_q, hard_val_d;

  logic signed [ACCW-1:0] llr_ext, msg_ext, acc_sum;
  logic                   last_cnt;

  assign llr_ext  = {{(ACCW-W){bus.i_llr[W-1]}}, bus.i_llr};
  assign msg_ext  = {{(ACCW-W){bus.i_msg[W-1]}}, bus.i_msg};
  assign acc_sum  = acc_q + msg_ext;
  assign last_cnt = (cnt_q == CW'(DEG-1));

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    acc_d      = acc_q;
    buf_d      = buf_q;
    hard_d     = hard_q;
    hard_val_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.i_llr_val) begin
          acc_d   = llr_ext;
          cnt_d   = '0;
          state_d = ACC;
        end
      end
      ACC: begin
        if (bus.i_msg_val) begin
          buf_d[cnt_q] = bus.i_msg;
          acc_d        = acc_sum;
          if (last_cnt) begin
            hard_d     = acc_sum[ACCW-1];
            hard_val_d = 1'b1;
            cnt_d      = '0;
            state_d    = OUT;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      OUT: begin
        if (bus.i_ready) begin
          if (last_cnt) begin
            cnt_d   = '0;
            state_d = IDLE;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge xrst) begin
    if (!xrst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      acc_q      <= '0;
      hard_q     <= 1'b0;
      hard_val_q <= 1'b0;
      for (int i = 0; i < DEG; i++) buf_q[i] <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      acc_q      <= acc_d;
      hard_q     <= hard_d;
      hard_val_q <= hard_val_d;
      for (int i = 0; i < DEG; i++) buf_q[i] <= buf_d[i];
    end
  end

`ifdef LDPC_COL_SAT_EN
  localparam logic signed [ACCW-1:0] SAT_MAX = ACCW'((64'sd1 <<< (W-1)) - 64'sd1);
  logic signed [ACCW-1:0] buf_ext, diff;
  always_comb begin
    buf_ext = {{(ACCW-W){buf_q[cnt_q][W-1]}}, buf_q[cnt_q]};
    diff    = acc_q - buf_ext;
    if (diff > SAT_MAX)       bus.o_msg = SAT_MAX[W-1:0];
    else if (diff < -SAT_MAX) bus.o_msg = W'(-SAT_MAX);
    else                      bus.o_msg = diff[W-1:0];
  end
`else
  // Low W bits of the difference only depend on the low W bits of the operands.
  assign bus.o_msg = acc_q[W-1:0] - buf_q[cnt_q];
`endif

  assign bus.o_msg_val  = (state_q == OUT);
  assign bus.o_busy     = (state_q != IDLE);
  assign bus.o_hard     = hard_q;
  assign bus.o_hard_val = hard_val_q;
endmodule

// File: tb/tb_ldpc_col_update.sv
// Directed bench for ldpc_col_update (W=16, DEG=3): vector table plus stall, noise and reset sequences.
module tb_ldpc_col_update;
  logic clk  = 1'b0;
  logic xrst = 1'b0;
  int   n_checks = 0;
  int   n_pass   = 0;

  always #5 clk = ~clk;

  ldpc_col_update_if #(.W(16)) bus ();

  ldpc_col_update #(.W(16), .DEG(3), .ACCW(20)) dut (
    .clk  (clk),
    .xrst (xrst),
    .bus  (bus)
  );

  typedef struct {
    logic signed [15:0] llr;
    logic signed [15:0] m0, m1, m2;
    logic               hard;
    logic signed [15:0] o0, o1, o2;
  } vec_t;

  task automatic chk(input string name, input logic signed [31:0] act, input logic signed [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_col(input vec_t v, input int stall, input bit noise, input string tag);
    logic signed [15:0] m [3];
    logic signed [15:0] e [3];
    m = '{v.m0, v.m1, v.m2};
    e = '{v.o0, v.o1, v.o2};
    if (noise) begin
      bus.i_msg_val = 1'b1;
      bus.i_msg     = 16'sd99;
      tick();
      bus.i_msg_val = 1'b0;
      chk({tag, " idle_ignores_msg busy"}, bus.o_busy, 0);
    end
    bus.i_llr     = v.llr;
    bus.i_llr_val = 1'b1;
    tick();
    bus.i_llr_val = 1'b0;
    chk({tag, " busy_after_llr"}, bus.o_busy, 1);
    for (int k = 0; k < 3; k++) begin
      bus.i_msg     = m[k];
      bus.i_msg_val = 1'b1;
      if (noise && k == 1) begin
        bus.i_llr     = 16'sd500;
        bus.i_llr_val = 1'b1;
      end
      if (k < 2) begin
        tick();
        chk({tag, " no_early_out"}, bus.o_msg_val, 0);
      end else begin
        tick();
      end
      bus.i_llr_val = 1'b0;
    end
    bus.i_msg_val = 1'b0;
    chk({tag, " hard_val_pulse"}, bus.o_hard_val, 1);
    chk({tag, " hard"}, bus.o_hard, v.hard);
    for (int s = 0; s < stall; s++) begin
      bus.i_ready = 1'b0;
      chk({tag, " stall_msg_val"}, bus.o_msg_val, 1);
      chk({tag, " stall_msg"}, bus.o_msg, e[0]);
      tick();
    end
    for (int k = 0; k < 3; k++) begin
      chk({tag, " msg_val"}, bus.o_msg_val, 1);
      chk($sformatf("%s o_msg[%0d]", tag, k), bus.o_msg, e[k]);
      bus.i_ready = 1'b1;
      tick();
      bus.i_ready = 1'b0;
      if (k == 0) chk({tag, " hard_val_one_cycle"}, bus.o_hard_val, 0);
    end
    chk({tag, " idle_msg_val"}, bus.o_msg_val, 0);
    chk({tag, " idle_busy"}, bus.o_busy, 0);
    chk({tag, " hard_held"}, bus.o_hard, v.hard);
  endtask

  vec_t vecs [5];
  vec_t case1;

  initial begin
    bus.i_llr     = '0;
    bus.i_llr_val = 1'b0;
    bus.i_msg     = '0;
    bus.i_msg_val = 1'b0;
    bus.i_ready   = 1'b0;

    case1   = '{llr: 16'sd10, m0: 16'sd5, m1: -16'sd3, m2: 16'sd7, hard: 1'b0,
                o0: 16'sd14, o1: 16'sd22, o2: 16'sd12};
    vecs[0] = case1;
`ifdef LDPC_COL_SAT_EN
    vecs[1] = '{llr: 16'sd30000, m0: 16'sd30000, m1: 16'sd1, m2: 16'sd1, hard: 1'b0,
                o0: 16'sd30002, o1: 16'sd32767, o2: 16'sd32767};
`else
    vecs[1] = '{llr: 16'sd30000, m0: 16'sd30000, m1: 16'sd1, m2: 16'sd1, hard: 1'b0,
                o0: 16'sd30002, o1: -16'sd5535, o2: -16'sd5535};
`endif
    vecs[2] = '{llr: 16'sd0, m0: 16'sd0, m1: 16'sd0, m2: 16'sd0, hard: 1'b0,
                o0: 16'sd0, o1: 16'sd0, o2: 16'sd0};
    vecs[3] = '{llr: -16'sd1, m0: 16'sd0, m1: 16'sd0, m2: 16'sd0, hard: 1'b1,
                o0: -16'sd1, o1: -16'sd1, o2: -16'sd1};
    vecs[4] = '{llr: -16'sd100, m0: -16'sd20, m1: -16'sd30, m2: 16'sd10, hard: 1'b1,
                o0: -16'sd120, o1: -16'sd110, o2: -16'sd150};

    #12;
    chk("reset o_busy", bus.o_busy, 0);
    chk("reset o_msg_val", bus.o_msg_val, 0);
    chk("reset o_hard", bus.o_hard, 0);
    chk("reset o_hard_val", bus.o_hard_val, 0);
    xrst = 1'b1;
    tick();

    for (int i = 0; i < 5; i++) run_col(vecs[i], 0, 1'b0, $sformatf("vec%0d", i));

    // Abort a column mid-accumulation while o_hard still holds 1 from the last vector.
    bus.i_llr     = 16'sd10;
    bus.i_llr_val = 1'b1;
    tick();
    bus.i_llr_val = 1'b0;
    bus.i_msg_val = 1'b1;
    bus.i_msg     = 16'sd5;
    tick();
    bus.i_msg     = -16'sd3;
    tick();
    bus.i_msg_val = 1'b0;
    xrst = 1'b0;
    #1;
    chk("abort o_busy", bus.o_busy, 0);
    chk("abort o_msg_val", bus.o_msg_val, 0);
    chk("abort o_hard", bus.o_hard, 0);
    chk("abort o_hard_val", bus.o_hard_val, 0);
    tick();
    xrst = 1'b1;
    tick();
    chk("after_abort idle", bus.o_busy, 0);
    run_col(case1, 0, 1'b0, "post_reset");

    run_col(case1, 3, 1'b0, "stall");
    run_col(case1, 0, 1'b1, "noise");

    tick();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
